chip8_mem_arbiter: RTL and testbench

Single-port memory arbiter for the CHIP-8 core. It shares the 4 KiB synchronous `chip8_mem` array between three requesters:
- the CPU (instruction fetch plus data read/write);
- the sprite/draw engine (read-only);
- the ROM/font loader (write-only).

It sits between `chip8_cpu`, the draw engine and the loader on one side and the memory's address/data pins on the other. It sequences accesses into a one-access-per-cycle pipeline with a fixed 2-cycle read latency.

---
 rtl/chip8_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
// Single-port arbiter for the 4 KiB CHIP-8 memory. Three requesters share the
// synchronous array: the CPU (read/write), the draw engine (read-only) and the
// ROM/font loader (write-only). Accepted accesses are registered onto the
// memory pins one cycle later. Read data returns two cycles after acceptance.
//
// Optional feature macro: CHIP8_ARB_WRPROT_EN
//   When defined, CPU writes below PROT_TOP are consumed without touching
//   memory, and wr_err pulses. When undefined, wr_err is tied low.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   cpu_req/we/addr/wdata       CPU request; cpu_gnt, cpu_rvalid, cpu_rdata
//   gpu_req/addr                draw-engine read; gpu_gnt, gpu_rvalid, gpu_rdata
//   ldr_active/req/addr/wdata   loader ownership and write; ldr_gnt
//   cpu_hold                    CPU stall while the loader owns memory
//   wr_err                      protected CPU write pulse
//   mem_en/we/addr/wdata        registered memory strobes
//   mem_rdata                   memory read data, one cycle after mem_en
module chip8_mem_arbiter #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] PROT_TOP = 12'h200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] gpu_rdata,
  input  logic              ldr_active,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              cpu_hold,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_GPU  = 2'd2
  } tag_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              rr_gpu_r;      // 1 = GPU wins the next contended cycle
  tag_t              tag1_r;        // owner of the read currently on mem pins
  logic              cpu_rvalid_r;
  logic              gpu_rvalid_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              cpu_gnt_s;
  logic              gpu_gnt_s;
  logic              ldr_gnt_s;
  logic              acc_cpu_s;
  logic              acc_gpu_s;
  logic              acc_ldr_s;
  logic              cpu_wr_blocked_s;

`ifdef CHIP8_ARB_WRPROT_EN
  logic              wr_err_r;
  assign cpu_wr_blocked_s = cpu_we && (cpu_addr < PROT_TOP);
  assign wr_err           = wr_err_r;
`else
  assign cpu_wr_blocked_s = 1'b0;
  assign wr_err           = 1'b0;
`endif

  assign acc_cpu_s = cpu_req && cpu_gnt_s;
  assign acc_gpu_s = gpu_req && gpu_gnt_s;
  assign acc_ldr_s = ldr_req && ldr_gnt_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (ldr_active) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // No grants are issued here. A read still in stage 2 returns this
        // cycle. With stage 1 empty, nothing is left in flight after this edge.
        if (tag1_r == TAG_NONE) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (!ldr_active) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Grant and hold outputs
  always_comb begin
    cpu_gnt_s = 1'b0;
    gpu_gnt_s = 1'b0;
    ldr_gnt_s = 1'b0;
    cpu_hold  = ldr_active || (state_r != ST_RUN);
    case (state_r)
      ST_RUN: begin
        if (ldr_active) begin
          cpu_gnt_s = 1'b0;
          gpu_gnt_s = 1'b0;
        end else if (cpu_req && gpu_req) begin
          cpu_gnt_s = !rr_gpu_r;
          gpu_gnt_s = rr_gpu_r;
        end else begin
          cpu_gnt_s = cpu_req;
          gpu_gnt_s = gpu_req;
        end
      end
      ST_DRAIN: begin
        ldr_gnt_s = 1'b0;
      end
      ST_LOAD: begin
        ldr_gnt_s = ldr_req && ldr_active;
      end
      default: begin
        ldr_gnt_s = 1'b0;
      end
    endcase
  end

  assign cpu_gnt = cpu_gnt_s;
  assign gpu_gnt = gpu_gnt_s;
  assign ldr_gnt = ldr_gnt_s;

  // Round-robin pointer: remembers which of CPU/GPU was granted last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_gpu_r <= 1'b0;
    end else if (acc_cpu_s) begin
      rr_gpu_r <= 1'b1;
    end else if (acc_gpu_s) begin
      rr_gpu_r <= 1'b0;
    end else begin
      rr_gpu_r <= rr_gpu_r;
    end
  end

  // Memory pin registers. The address and data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (acc_ldr_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= 1'b1;
      mem_addr_r  <= ldr_addr;
      mem_wdata_r <= ldr_wdata;
    end else if (acc_cpu_s && !cpu_wr_blocked_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= cpu_we;
      mem_addr_r  <= cpu_addr;
      mem_wdata_r <= cpu_wdata;
    end else if (acc_gpu_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= gpu_addr;
      mem_wdata_r <= mem_wdata_r;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= mem_addr_r;
      mem_wdata_r <= mem_wdata_r;
    end
  end

  // Two-stage read owner pipeline. Stage 2 is kept as one valid bit per requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_r       <= TAG_NONE;
      cpu_rvalid_r <= 1'b0;
      gpu_rvalid_r <= 1'b0;
    end else begin
      if (acc_cpu_s && !cpu_we) begin
        tag1_r <= TAG_CPU;
      end else if (acc_gpu_s) begin
        tag1_r <= TAG_GPU;
      end else begin
        tag1_r <= TAG_NONE;
      end
      cpu_rvalid_r <= (tag1_r == TAG_CPU);
      gpu_rvalid_r <= (tag1_r == TAG_GPU);
    end
  end

`ifdef CHIP8_ARB_WRPROT_EN
  // Protected-write pulse, aligned with the cycle the access would have used
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= acc_cpu_s && cpu_wr_blocked_s;
    end
  end
`endif

  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign gpu_rvalid = gpu_rvalid_r;
  assign cpu_rdata  = mem_rdata;
  assign gpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Testbench for chip8_mem_arbiter. It uses a behavioural synchronous memory.
// A stimulus process issues directed requests and queues the expected read
// responses and memory accesses. A monitor process pops and compares the
// queues whenever the DUT presents rvalid or mem_en.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        gpu_req;
  logic [11:0] gpu_addr;
  logic        gpu_gnt, gpu_rvalid;
  logic [7:0]  gpu_rdata;
  logic        ldr_active, ldr_req;
  logic [11:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_gnt, cpu_hold, wr_err;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  chip8_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(gpu_gnt),
    .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .ldr_active(ldr_active), .ldr_req(ldr_req), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
    .cpu_hold(cpu_hold), .wr_err(wr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory. Preload happens while 'preload' is high.
  logic [7:0] tb_mem [0:4095];
  logic       preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= 8'h00;
      tb_mem[12'h200] <= 8'hA2;
      tb_mem[12'h300] <= 8'h3C;
      tb_mem[12'h050] <= 8'hF0;
    end else if (mem_en && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end else if (mem_en) begin
      mem_rdata <= tb_mem[mem_addr];
    end
  end

  typedef struct {logic is_gpu; logic [7:0] data; int due;} rd_t;
  typedef struct {logic we; logic [11:0] addr; logic [7:0] wdata; int due;} ma_t;
  rd_t rd_q[$];
  ma_t mem_q[$];
  rd_t rd_e;
  ma_t mem_e;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic g, input logic [7:0] d);
    rd_q.push_back('{is_gpu: g, data: d, due: cyc + 2});
  endtask

  task automatic push_mem(input logic w, input logic [11:0] a, input logic [7:0] d);
    mem_q.push_back('{we: w, addr: a, wdata: d, due: cyc + 1});
  endtask

  // Monitor: compares every presented response against the queues
  always @(negedge clk) begin
    if (cpu_rvalid || gpu_rvalid) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_unexpected: cpu_rvalid=%b gpu_rvalid=%b expected none", cpu_rvalid, gpu_rvalid);
      end else begin
        rd_e = rd_q.pop_front();
        check("rd_owner", 32'({gpu_rvalid, cpu_rvalid}), rd_e.is_gpu ? 32'd2 : 32'd1);
        check("rd_data", 32'(rd_e.is_gpu ? gpu_rdata : cpu_rdata), 32'(rd_e.data));
        check("rd_latency", 32'(cyc), 32'(rd_e.due));
      end
    end
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL mem_unexpected: mem_en=1 addr=0x%0h we=%b expected idle", mem_addr, mem_we);
      end else begin
        mem_e = mem_q.pop_front();
        check("mem_we", 32'(mem_we), 32'(mem_e.we));
        check("mem_addr", 32'(mem_addr), 32'(mem_e.addr));
        if (mem_e.we) check("mem_wdata", 32'(mem_wdata), 32'(mem_e.wdata));
        check("mem_latency", 32'(cyc), 32'(mem_e.due));
      end
    end
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
    gpu_req = 1'b0; gpu_addr = 12'h000;
    ldr_active = 1'b0; ldr_req = 1'b0; ldr_addr = 12'h000; ldr_wdata = 8'h00;
    step();
    step();
    preload = 1'b0;
    #2;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rvalid", 32'({cpu_rvalid, gpu_rvalid}), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    step();
    reset = 1'b0;

    // Reset mid-read: the accepted read must never return
    cpu_req = 1'b1; cpu_addr = 12'h200;
    #2 check("midrst_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0; reset = 1'b1;
    #2 check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    step();
    #2 check("midrst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("midrst_mem_addr2", 32'(mem_addr), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Contention: CPU first after reset, then alternating
    cpu_req = 1'b1; cpu_addr = 12'h300;
    gpu_req = 1'b1; gpu_addr = 12'h050;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("rr_cpu_gnt", 32'(cpu_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_gpu_gnt", 32'(gpu_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) begin
        push_rd(1'b0, 8'h3C); push_mem(1'b0, 12'h300, 8'h00);
      end else begin
        push_rd(1'b1, 8'hF0); push_mem(1'b0, 12'h050, 8'h00);
      end
      step();
    end
    cpu_req = 1'b0; gpu_req = 1'b0;
    repeat (3) step();

    // Single CPU read of 0x200
    cpu_req = 1'b1; cpu_addr = 12'h200;
    #2 check("rd200_gnt", 32'(cpu_gnt), 32'd1);
    check("rd200_gpu_gnt", 32'(gpu_gnt), 32'd0);
    push_rd(1'b0, 8'hA2); push_mem(1'b0, 12'h200, 8'h00);
    step();
    cpu_req = 1'b0;
    #2 check("rd200_idle_gnt", 32'(cpu_gnt), 32'd0);
    repeat (3) step();

    // CPU writes: 0x010 (protected when the feature is built in), then 0x200
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'h55;
    #2 check("wr010_gnt", 32'(cpu_gnt), 32'd1);
`ifndef CHIP8_ARB_WRPROT_EN
    push_mem(1'b1, 12'h010, 8'h55);
`endif
    step();
    cpu_addr = 12'h200; cpu_wdata = 8'h66;
`ifdef CHIP8_ARB_WRPROT_EN
    #2 check("wr010_err", 32'(wr_err), 32'd1);
`else
    #2 check("wr010_err", 32'(wr_err), 32'd0);
`endif
    check("wr200_gnt", 32'(cpu_gnt), 32'd1);
    push_mem(1'b1, 12'h200, 8'h66);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2 check("wr200_err", 32'(wr_err), 32'd0);
    repeat (3) step();

    // GPU read at N, loader takes over at N+1
    gpu_req = 1'b1; gpu_addr = 12'h050;
    #2 check("ld_gpu_gnt", 32'(gpu_gnt), 32'd1);
    push_rd(1'b1, 8'hF0); push_mem(1'b0, 12'h050, 8'h00);
    step();
    gpu_req = 1'b0; ldr_active = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    #2 check("ld_rise_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("ld_rise_hold", 32'(cpu_hold), 32'd1);
    step();
    ldr_req = 1'b1; ldr_addr = 12'h200; ldr_wdata = 8'h12;
    #2 check("drain_ldr_gnt", 32'(ldr_gnt), 32'd0);
    check("drain_hold", 32'(cpu_hold), 32'd1);
    step();
    #2 check("load_ldr_gnt", 32'(ldr_gnt), 32'd1);
    check("load_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("load_hold", 32'(cpu_hold), 32'd1);
    push_mem(1'b1, 12'h200, 8'h12);
    step();
    ldr_active = 1'b0;
    #2 check("ld_fall_ldr_gnt", 32'(ldr_gnt), 32'd0);
    check("ld_fall_hold", 32'(cpu_hold), 32'd1);
    check("ld_fall_cpu_gnt", 32'(cpu_gnt), 32'd0);
    step();
    ldr_req = 1'b0;
    #2 check("run_hold", 32'(cpu_hold), 32'd0);
    check("run_cpu_gnt", 32'(cpu_gnt), 32'd1);
    push_rd(1'b0, 8'h12); push_mem(1'b0, 12'h200, 8'h00);
    step();
    cpu_req = 1'b0;

    repeat (5) step();
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
